// File: rtl/hyper_boot_cfg.sv
// -----------------------------------------------------------------------------
// hyper_boot_cfg
//   Power-up boot sequencer for a HyperBus memory device. After a fixed
//   power-up wait it enables the device supply through a register-bus write,
//   programs the device CFG0 register over an AXI-style write channel, turns
//   the supply-enable register back off, and then opens the gate for normal
//   traffic. Any bus fault ends the sequence in a terminal error state.
//
//   Optional feature macro: HYPER_BOOT_CFG_RETRY_EN
//     When defined, a fault restarts the sequence at REG_ON (skipping the
//     power-up wait), up to 3 retries; the 4th fault is terminal. The retry
//     counter clears only on reset.
//
// Ports
//   clk            clock
//   rst_n          asynchronous reset, active-high (name kept from the codebase)
//   reg_*          register bus: addr/write/wdata/wstrb/valid out, ready/error in
//   aw_*           write address channel: addr/valid out, ready in
//   w_*            write data channel: data/strb/valid out, ready in
//   b_*            write response channel: resp/valid in, ready out
//   traffic_en_o   gate for normal traffic (high only once sequence is done)
//   done_o         sequence completed (registered)
//   err_o          sequence failed (registered)
// -----------------------------------------------------------------------------
module hyper_boot_cfg #(
    parameter int unsigned           WAIT_CYCLES = 16,
    parameter int unsigned           REG_AW      = 8,
    parameter int unsigned           AXI_AW      = 32,
    parameter logic [AXI_AW-1:0]     CFG_ADDR    = 32'h8000_1000,
    parameter logic [15:0]           CFG0_VAL    = 16'h8F17
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [REG_AW-1:0] reg_addr_o,
    output logic              reg_write_o,
    output logic [31:0]       reg_wdata_o,
    output logic [3:0]        reg_wstrb_o,
    output logic              reg_valid_o,
    input  logic              reg_ready_i,
    input  logic              reg_error_i,
    output logic [AXI_AW-1:0] aw_addr_o,
    output logic              aw_valid_o,
    input  logic              aw_ready_i,
    output logic [31:0]       w_data_o,
    output logic [3:0]        w_strb_o,
    output logic              w_valid_o,
    input  logic              w_ready_i,
    input  logic [1:0]        b_resp_i,
    input  logic              b_valid_i,
    output logic              b_ready_o,
    output logic              traffic_en_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int unsigned       CNT_W     = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [REG_AW-1:0] PWR_REG   = REG_AW'(8'h1C);

    typedef enum logic [2:0] {
        S_WAIT,
        S_REG_ON,
        S_CFG_AW_W,
        S_CFG_B,
        S_REG_OFF,
        S_DONE,
        S_ERROR
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic             aw_done, w_done;
    logic             done_q, err_q;
    logic             fault;

`ifdef HYPER_BOOT_CFG_RETRY_EN
    logic [1:0]       retry_cnt;
`endif

    // Next state and Moore outputs. Payloads depend only on state, so they
    // cannot change while a valid is held.
    always_comb begin
        state_next  = state;
        fault       = 1'b0;
        reg_addr_o  = '0;
        reg_write_o = 1'b0;
        reg_wdata_o = '0;
        reg_wstrb_o = '0;
        reg_valid_o = 1'b0;
        aw_addr_o   = '0;
        aw_valid_o  = 1'b0;
        w_data_o    = '0;
        w_strb_o    = '0;
        w_valid_o   = 1'b0;
        b_ready_o   = 1'b0;

        case (state)
            S_WAIT: begin
                if (wait_cnt == WAIT_LAST) state_next = S_REG_ON;
            end
            S_REG_ON, S_REG_OFF: begin
                reg_valid_o = 1'b1;
                reg_write_o = 1'b1;
                reg_addr_o  = PWR_REG;
                reg_wdata_o = (state == S_REG_ON) ? 32'h1 : 32'h0;
                reg_wstrb_o = 4'hF;
                if (reg_ready_i) begin
                    if (reg_error_i) fault = 1'b1;
                    else state_next = (state == S_REG_ON) ? S_CFG_AW_W : S_DONE;
                end
            end
            S_CFG_AW_W: begin
                aw_addr_o  = CFG_ADDR;
                w_data_o   = {CFG0_VAL, CFG0_VAL};
                w_strb_o   = 4'hF;
                aw_valid_o = !aw_done;
                w_valid_o  = !w_done;
                // Each channel completes either earlier (done flag) or now.
                if ((aw_done || aw_ready_i) && (w_done || w_ready_i))
                    state_next = S_CFG_B;
            end
            S_CFG_B: begin
                b_ready_o = 1'b1;
                if (b_valid_i) begin
                    if (b_resp_i == 2'b00) state_next = S_REG_OFF;
                    else fault = 1'b1;
                end
            end
            S_DONE:  state_next = S_DONE;
            S_ERROR: state_next = S_ERROR;
            default: state_next = S_ERROR;
        endcase

`ifdef HYPER_BOOT_CFG_RETRY_EN
        if (fault) state_next = (retry_cnt == 2'd3) ? S_ERROR : S_REG_ON;
`else
        if (fault) state_next = S_ERROR;
`endif
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state    <= S_WAIT;
            wait_cnt <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_WAIT && state_next == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
            else                                         wait_cnt <= '0;
            // Done flags live only while the write phase is in progress.
            if (state == S_CFG_AW_W && state_next == S_CFG_AW_W) begin
                aw_done <= aw_done | aw_ready_i;
                w_done  <= w_done  | w_ready_i;
            end else begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            done_q <= (state_next == S_DONE);
            err_q  <= (state_next == S_ERROR);
        end
    end

`ifdef HYPER_BOOT_CFG_RETRY_EN
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)                              retry_cnt <= '0;
        else if (fault && retry_cnt != 2'd3)    retry_cnt <= retry_cnt + 2'd1;
    end
`endif

    assign done_o       = done_q;
    assign traffic_en_o = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_hyper_boot_cfg.sv
// -----------------------------------------------------------------------------
// tb_hyper_boot_cfg
//   Directed bench for hyper_boot_cfg. The main process issues each scenario
//   and pushes the expected bus writes into per-channel queues; a monitor
//   process pops and compares whenever the DUT completes a handshake, and
//   also checks payload stability while a valid is held. A responder process
//   drives the ready/error/response inputs.
// -----------------------------------------------------------------------------
module tb_hyper_boot_cfg;

    localparam int unsigned WAIT_CYCLES = 16;
    localparam logic [31:0] CFG_ADDR    = 32'h8000_1000;
    localparam logic [31:0] CFG_WORD    = 32'h8F17_8F17;

    logic        clk;
    logic        rst_n;
    logic [7:0]  reg_addr_o;
    logic        reg_write_o;
    logic [31:0] reg_wdata_o;
    logic [3:0]  reg_wstrb_o;
    logic        reg_valid_o;
    logic        reg_ready_i;
    logic        reg_error_i;
    logic [31:0] aw_addr_o;
    logic        aw_valid_o;
    logic        aw_ready_i;
    logic [31:0] w_data_o;
    logic [3:0]  w_strb_o;
    logic        w_valid_o;
    logic        w_ready_i;
    logic [1:0]  b_resp_i;
    logic        b_valid_i;
    logic        b_ready_o;
    logic        traffic_en_o;
    logic        done_o;
    logic        err_o;

    hyper_boot_cfg #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .REG_AW      (8),
        .AXI_AW      (32),
        .CFG_ADDR    (CFG_ADDR),
        .CFG0_VAL    (16'h8F17)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .reg_addr_o   (reg_addr_o),
        .reg_write_o  (reg_write_o),
        .reg_wdata_o  (reg_wdata_o),
        .reg_wstrb_o  (reg_wstrb_o),
        .reg_valid_o  (reg_valid_o),
        .reg_ready_i  (reg_ready_i),
        .reg_error_i  (reg_error_i),
        .aw_addr_o    (aw_addr_o),
        .aw_valid_o   (aw_valid_o),
        .aw_ready_i   (aw_ready_i),
        .w_data_o     (w_data_o),
        .w_strb_o     (w_strb_o),
        .w_valid_o    (w_valid_o),
        .w_ready_i    (w_ready_i),
        .b_resp_i     (b_resp_i),
        .b_valid_i    (b_valid_i),
        .b_ready_o    (b_ready_o),
        .traffic_en_o (traffic_en_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Expected transactions and injected responses.
    logic [31:0] exp_reg_q[$];
    logic [31:0] exp_aw_q[$];
    logic [31:0] exp_w_q[$];
    logic        reg_err_q[$];
    logic [1:0]  b_resp_q[$];

    int   cyc = 0;
    int   rel_cyc = 0;
    int   first_reg_cyc = -1;
    int   aw_hs_cyc = 0;
    int   w_hs_cyc = 0;
    int   aw_delay = 0;
    int   aw_cnt = 0;
    logic b_hold = 1'b0;
    logic reg_hs_seen = 1'b0;
    logic b_hs_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_vec++;
        n_bad++;
        $display("FAIL %s: got %s, required none (t=%0t)", name, what, $time);
    endtask

    // Responder: updates inputs 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (reg_hs_seen) begin
            if (reg_err_q.size() > 0) void'(reg_err_q.pop_front());
            reg_hs_seen = 1'b0;
        end
        if (b_hs_seen) begin
            if (b_resp_q.size() > 0) void'(b_resp_q.pop_front());
            b_hs_seen = 1'b0;
        end
        reg_ready_i = 1'b1;
        reg_error_i = (reg_err_q.size() > 0) ? reg_err_q[0] : 1'b0;
        b_resp_i    = (b_resp_q.size() > 0) ? b_resp_q[0] : 2'b00;
        b_valid_i   = !b_hold;
        w_ready_i   = 1'b1;
        if (aw_delay == 0) begin
            aw_ready_i = 1'b1;
        end else if (!aw_valid_o) begin
            aw_ready_i = 1'b0;
            aw_cnt     = 0;
        end else begin
            aw_ready_i = (aw_cnt >= aw_delay);
            aw_cnt++;
        end
    end

    // Monitor: samples on the falling edge, between active edges.
    logic         reg_pend = 1'b0, aw_pend = 1'b0, w_pend = 1'b0;
    logic [45:0]  reg_saved;
    logic [32:0]  aw_saved;
    logic [36:0]  w_saved;
    logic         aw_seen = 1'b0, w_seen = 1'b0;
    logic         b_ready_prev = 1'b0;
    logic         done_watch = 1'b0;
    logic         done_exp = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            reg_pend = 1'b0; aw_pend = 1'b0; w_pend = 1'b0;
            aw_seen = 1'b0; w_seen = 1'b0; b_ready_prev = 1'b0;
            done_watch = 1'b0; first_reg_cyc = -1;
        end else begin
            if (done_watch) begin
                chk("done_after_reg_off", {done_o, traffic_en_o}, done_exp ? 2'b11 : 2'b00);
                done_watch = 1'b0;
            end
            if (first_reg_cyc < 0 && reg_valid_o) first_reg_cyc = cyc - rel_cyc;

            if (reg_pend)
                chk("reg_hold", {reg_valid_o, reg_write_o, reg_addr_o, reg_wdata_o, reg_wstrb_o}, reg_saved);
            if (aw_pend) chk("aw_hold", {aw_valid_o, aw_addr_o}, aw_saved);
            if (w_pend)  chk("w_hold", {w_valid_o, w_data_o, w_strb_o}, w_saved);

            if (reg_valid_o && reg_ready_i) begin
                reg_hs_seen = 1'b1;
                aw_seen = 1'b0;
                w_seen  = 1'b0;
                if (exp_reg_q.size() == 0) fail_now("reg_extra", "unexpected reg write");
                else chk("reg_write", {reg_write_o, reg_addr_o, reg_wdata_o, reg_wstrb_o},
                         {1'b1, 8'h1C, exp_reg_q.pop_front(), 4'hF});
                if (reg_wdata_o == 32'h0) begin
                    chk("done_before_reg_off", done_o, 1'b0);
                    done_watch = 1'b1;
                    done_exp   = !reg_error_i;
                end
            end
            if (aw_valid_o && aw_ready_i) begin
                aw_seen   = 1'b1;
                aw_hs_cyc = cyc;
                if (exp_aw_q.size() == 0) fail_now("aw_extra", "unexpected AW");
                else chk("aw_addr", aw_addr_o, exp_aw_q.pop_front());
            end
            if (w_valid_o && w_ready_i) begin
                w_seen   = 1'b1;
                w_hs_cyc = cyc;
                if (exp_w_q.size() == 0) fail_now("w_extra", "unexpected W");
                else chk("w_data", {w_data_o, w_strb_o}, {exp_w_q.pop_front(), 4'hF});
            end
            if (b_ready_o && !b_ready_prev) chk("b_after_aw_and_w", {aw_seen, w_seen}, 2'b11);
            if (b_ready_o && b_valid_i) b_hs_seen = 1'b1;

            b_ready_prev = b_ready_o;
            reg_pend  = reg_valid_o && !reg_ready_i;
            reg_saved = {reg_valid_o, reg_write_o, reg_addr_o, reg_wdata_o, reg_wstrb_o};
            aw_pend   = aw_valid_o && !aw_ready_i;
            aw_saved  = {aw_valid_o, aw_addr_o};
            w_pend    = w_valid_o && !w_ready_i;
            w_saved   = {w_valid_o, w_data_o, w_strb_o};
        end
    end

    function automatic logic [127:0] all_outs();
        return {reg_addr_o, reg_write_o, reg_wdata_o, reg_wstrb_o, reg_valid_o,
                aw_addr_o, aw_valid_o, w_data_o, w_strb_o, w_valid_o,
                b_ready_o, traffic_en_o, done_o, err_o};
    endfunction

    task automatic push_pass(input logic with_off);
        exp_reg_q.push_back(32'h1);
        exp_aw_q.push_back(CFG_ADDR);
        exp_w_q.push_back(CFG_WORD);
        if (with_off) exp_reg_q.push_back(32'h0);
    endtask

    // Holds reset, clears bench state, then releases just after an edge.
    task automatic start_run();
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        exp_reg_q.delete(); exp_aw_q.delete(); exp_w_q.delete();
        reg_err_q.delete(); b_resp_q.delete();
        aw_cnt = 0;
    endtask

    task automatic release_run();
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b0;
        rel_cyc = cyc;
    endtask

    task automatic wait_end(input string name);
        bit ended = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done_o || err_o) begin
                ended = 1;
                break;
            end
        end
        if (!ended) fail_now(name, "timeout waiting for done/err");
        repeat (2) @(negedge clk);
    endtask

    task automatic end_checks(input string name, input logic exp_done);
        chk({name, "_status"}, {done_o, traffic_en_o, err_o}, exp_done ? 3'b110 : 3'b001);
        chk({name, "_drained"}, exp_reg_q.size() + exp_aw_q.size() + exp_w_q.size(), 0);
    endtask

    initial begin
        bit got_b;
        rst_n = 1'b1;
        reg_ready_i = 1'b1; reg_error_i = 1'b0;
        aw_ready_i = 1'b1; w_ready_i = 1'b1;
        b_resp_i = 2'b00; b_valid_i = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", all_outs(), '0);

        // Nominal sequence, all readies high
        start_run();
        aw_delay = 0;
        push_pass(1'b1);
        release_run();
        wait_end("nominal");
        chk("nominal_first_reg_cycle", first_reg_cyc, WAIT_CYCLES);
        end_checks("nominal", 1'b1);

        // AW ready delayed by 5 cycles, W immediate
        start_run();
        aw_delay = 5;
        push_pass(1'b1);
        release_run();
        wait_end("aw_delay");
        chk("aw_delay_w_first_by_5", aw_hs_cyc - w_hs_cyc, 5);
        end_checks("aw_delay", 1'b1);
        aw_delay = 0;

        // SLVERR on the first CFG0 write response
        start_run();
        push_pass(1'b0);
        b_resp_q.push_back(2'b10);
`ifdef HYPER_BOOT_CFG_RETRY_EN
        b_resp_q.push_back(2'b00);
        push_pass(1'b1);
        release_run();
        wait_end("bresp_fault");
        end_checks("bresp_fault", 1'b1);
`else
        release_run();
        wait_end("bresp_fault");
        end_checks("bresp_fault", 1'b0);
`endif

        // Register-bus error on every REG_ON attempt
        start_run();
`ifdef HYPER_BOOT_CFG_RETRY_EN
        for (int i = 0; i < 4; i++) begin
            reg_err_q.push_back(1'b1);
            exp_reg_q.push_back(32'h1);
        end
`else
        reg_err_q.push_back(1'b1);
        exp_reg_q.push_back(32'h1);
`endif
        release_run();
        wait_end("reg_error");
        end_checks("reg_error", 1'b0);

        // Reset pulse while CFG_B waits for a response
        start_run();
        b_hold = 1'b1;
        push_pass(1'b0);
        release_run();
        got_b = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (b_ready_o) begin
                got_b = 1;
                break;
            end
        end
        if (!got_b) fail_now("reset_mid_b_ready", "b_ready_o never asserted");
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("reset_mid_outputs", all_outs(), '0);
        chk("reset_mid_drained", exp_reg_q.size() + exp_aw_q.size() + exp_w_q.size(), 0);
        start_run();
        b_hold = 1'b0;
        push_pass(1'b1);
        release_run();
        wait_end("reset_mid");
        chk("reset_mid_first_reg_cycle", first_reg_cyc, WAIT_CYCLES);
        end_checks("reset_mid", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/hyper_boot_cfg.md
HYPER_BOOT_CFG -- requirements
Module: hyper_boot_cfg

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 16, power-up wait in clk cycles before the first bus access (minimum 1).
REQ-002 SHALL have parameter REG_AW, default 8, register-bus address width.
REQ-003 SHALL have parameter AXI_AW, default 32, write-port address width.
REQ-004 SHALL have parameter CFG_ADDR, default 32'h8000_1000, device CFG0 byte address.
REQ-005 SHALL have parameter CFG0_VAL, default 16'h8F17, CFG0 value; bit 3 = 0 selects variable latency.
REQ-006 SHALL have input clk, 1 bit, clock.
REQ-007 SHALL have input rst_n, 1 bit: reset, asynchronous, active-high.
REQ-008 SHALL have reg_addr_o, output, REG_AW bits, register-bus address.
REQ-009 SHALL have reg_write_o (1), reg_wdata_o (32) and reg_wstrb_o (4), all outputs: write flag, data and byte strobe.
REQ-010 SHALL have reg_valid_o (output, 1), reg_ready_i (input, 1) and reg_error_i (input, 1): register-bus handshake and error.
REQ-011 SHALL have aw_addr_o (output, AXI_AW), aw_valid_o (output, 1) and aw_ready_i (input, 1): write address channel.
REQ-012 SHALL have w_data_o (output, 32), w_strb_o (output, 4), w_valid_o (output, 1) and w_ready_i (input, 1): write data channel.
REQ-013 SHALL have b_resp_i (input, 2), b_valid_i (input, 1) and b_ready_o (output, 1): write response channel.
REQ-014 SHALL have traffic_en_o (output, 1), done_o (output, 1) and err_o (output, 1): gate for normal traffic, sequence complete, sequence failed.

Function
REQ-015 SHALL use states WAIT, REG_ON, CFG_AW_W, CFG_B, REG_OFF, DONE and ERROR, entering WAIT on reset.
REQ-016 In WAIT, SHALL count WAIT_CYCLES cycles, then enter REG_ON.
REQ-017 In REG_ON, SHALL drive reg_valid_o=1, reg_write_o=1, reg_addr_o=8'h1C, reg_wdata_o=32'h1 and reg_wstrb_o=4'hF until reg_ready_i=1.
REQ-018 When reg_ready_i=1 in REG_ON: reg_error_i=0 SHALL enter CFG_AW_W; reg_error_i=1 SHALL be treated as a fault (REQ-027).
REQ-019 In CFG_AW_W, SHALL drive aw_addr_o=CFG_ADDR, w_data_o={CFG0_VAL,CFG0_VAL} and w_strb_o=4'hF.
REQ-020 In CFG_AW_W, SHALL hold aw_valid_o and w_valid_o independently, each until its own ready; AW and W may complete in the same cycle or in either order.
REQ-021 SHALL enter CFG_B only after both the AW and the W handshake are done.
REQ-022 In CFG_B, SHALL assert b_ready_o=1; on b_valid_i, b_resp_i=2'b00 SHALL enter REG_OFF, and any other value SHALL be a fault.
REQ-023 In REG_OFF, SHALL behave as REG_ON but with reg_wdata_o=32'h0; on success it SHALL enter DONE.
REQ-024 DONE SHALL be terminal; in DONE, traffic_en_o=1 and done_o=1, registered, asserted the cycle after leaving REG_OFF.
REQ-025 ERROR SHALL be terminal; in ERROR, err_o=1 and traffic_en_o=0.
REQ-026 SHALL hold all valids low and traffic_en_o=0 in every state except those stated above.
REQ-027 A fault SHALL enter ERROR, except when the retry feature (REQ-031) is compiled in.
REQ-028 Once a valid is raised, SHALL keep it and its payload stable until the handshake (no retraction).

Reset
REQ-029 Reset SHALL be asserted while rst_n=1 and SHALL immediately force all outputs to 0, state to WAIT, and counters and handshake-done flags to 0.
REQ-030 Reset asserted mid-transaction SHALL abandon that transaction; after release the full sequence SHALL restart from WAIT.

Configuration
REQ-031 With HYPER_BOOT_CFG_RETRY_EN defined, a fault SHALL restart the sequence at REG_ON (no WAIT), up to 3 retries; the 4th fault SHALL enter ERROR; the retry counter SHALL clear only on reset.
REQ-032 Without HYPER_BOOT_CFG_RETRY_EN, the first fault SHALL enter ERROR and the retry counter SHALL not exist.

Verification
REQ-033 Ready signals always 1, OKAY responses -> reg write 0x1C/0x1 at cycle WAIT_CYCLES; AW 0x8000_1000 with W 0x8F178F17 strb 0xF; reg write 0x1C/0x0; done_o=1.
REQ-034 aw_ready_i delayed 5 cycles, w_ready_i 0 cycles -> W accepted first, CFG_B entered only after AW; payloads stable throughout.
REQ-035 b_resp_i=2'b10 on first attempt -> without macro: err_o=1 and traffic_en_o=0; with macro: restart at REG_ON, done_o=1 after second pass.
REQ-036 reg_error_i=1 on all four REG_ON attempts with macro defined -> exactly 4 REG_ON transactions, then err_o=1.
REQ-037 rst_n=1 pulsed while CFG_B is waiting -> outputs 0 immediately; after release, WAIT count restarts and the full sequence completes.
